alu_seq_pw: RTL and testbench
=============================

// Module: alu_seq_pw
// PURPOSE
//   Parametrised, registered multi-cycle ALU: the next-generation successor of the 8-bit combinational op_sel ALU.
//   Adds a valid/ready handshake on both sides and a persistent flag register (C/Z/N/V) for multi-word carry chaining.
//   Adds multi-cycle ops: a barrel-free shift-left by variable amount and a shift-add multiplier.
//   Sits between the datapath sequencer and the register file; one operation in flight at a time.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=4); SHW = $clog2(WIDTH) is derived locally
//   MUL_EN  1   1: op 7 is a WIDTH-cycle multiply; 0: op 7 completes in 1 cycle with result 0
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operands/op valid
//   in_ready   out  1      block idle and able to accept (= state==IDLE)
//   Ain        in   WIDTH  operand A
//   Bin        in   WIDTH  operand B (SHL uses Bin[SHW-1:0] as shift count)
//   Carryin    in   1      external carry-in
//   carry_sel  in   1      0: use Carryin; 1: use stored carry flag (chaining)
//   op_sel     in   3      operation select (see BEHAVIOUR)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   alu_out    out  WIDTH  registered result
//   Carryout   out  1      carry flag C (registered)
//   flag_z     out  1      result == 0
//   flag_n     out  1      result MSB
//   flag_v     out  1      signed overflow (ADD/SUB only)
// BEHAVIOUR
//   Reset: state IDLE; alu_out=0, Carryout=0, flag_z/n/v=0, out_valid=0; in_ready=1. Aborts any in-flight op.
//   FSM: IDLE --(in_valid)--> BUSY or DONE; BUSY --(count done)--> DONE; DONE --(out_ready)--> IDLE.
//   Accept: in_valid && in_ready. Ain, Bin, op_sel and c are captured at accept.
//     c = carry_sel ? Carryout : Carryin.
//     Input changes after accept are ignored.
//   in_valid while not in IDLE: ignored, not queued. out_ready outside DONE: no effect.
//   DONE holds alu_out/flags stable until out_ready; accept of next op only after return to IDLE.
//   Ops (results modulo 2^WIDTH):
//     0 ADD  A+B+c          C=carry out    V=signed ovf
//     1 SUB  A+~B+c         C=1 means no borrow (c=1 gives plain A-B)    V=signed ovf
//     2 AND  3 OR  4 XOR  5 NOT A   C=0 V=0
//     6 SHL  A<<k, k=Bin[SHW-1:0], one bit per cycle; C=last bit shifted out (0 if k=0); V=0
//     7 MUL  low WIDTH bits of A*B, shift-add one bit per cycle; C=|high WIDTH bits; V=0
//   Latency accept->out_valid:
//     ops 0-5: 1 cycle
//     SHL: k+1 cycles
//     MUL: WIDTH+1 cycles (1 if MUL_EN=0)
//   Flags update only on the IDLE/BUSY->DONE transition: flag_z=(result==0), flag_n=result[WIDTH-1].
//   carry_sel=1 right after reset uses C=0.
//   Reset asserted in any state wins over all other inputs the same cycle.
// TESTING (WIDTH=8, MUL_EN=1)
//   ADD A=0xCC B=0x55 Carryin=1 carry_sel=0 -> 1 cycle later out_valid=1, alu_out=0x22, Carryout=1, Z=0 N=0 V=0
//   SUB A=0x08 B=0x06 Carryin=1 -> 0x02, C=1; then ADD carry_sel=1 A=0xFF B=0x00 -> 0x00, C=1, Z=1
//   SHL A=0xE1 B=3 -> out_valid 4 cycles after accept, alu_out=0x08, C=1; SHL B=0 -> A unchanged, C=0, 1 cycle
//   MUL A=0x10 B=0x06 -> 0x60, C=0 after 9 cycles; MUL A=0x20 B=0x10 -> 0x00, C=1, Z=1
//   out_ready=0 for 5 cycles in DONE, new in_valid pulses -> alu_out/flags stable, in_ready=0, pulses dropped
//   reset on 3rd BUSY cycle of MUL -> next cycle out_valid=0, in_ready=1, alu_out=0, all flags 0

Source files
------------

// File: rtl/alu_seq_pw.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pw
//  Description : Registered multi-cycle ALU with valid/ready handshakes, a
//                persistent C/Z/N/V flag register, serial SHL and shift-add MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_pw #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Carryin,
    input  logic             carry_sel,
    input  logic [2:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             Carryout,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int c_SHW = $clog2(WIDTH);
    localparam int c_CW  = c_SHW + 1;
    localparam logic [c_CW-1:0] c_MUL_CNT = c_CW'(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_mul;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_c;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_cf;
    logic               w_vf;
    logic [c_SHW-1:0]   w_shamt;
    logic               w_fast;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_busy_res;
    logic               w_busy_c;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);

    // Single-cycle result, computed straight from the inputs at accept time
    always_comb begin
        w_c     = carry_sel ? Carryout : Carryin;
        w_b_eff = (op_sel == c_OP_SUB) ? ~Bin : Bin;
        w_sum   = {1'b0, Ain} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_c};
        w_res   = '0;
        w_cf    = 1'b0;
        w_vf    = 1'b0;
        case (op_sel)
            c_OP_ADD, c_OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_vf  = (Ain[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != Ain[WIDTH-1]);
            end
            c_OP_AND: w_res = Ain & Bin;
            c_OP_OR:  w_res = Ain | Bin;
            c_OP_XOR: w_res = Ain ^ Bin;
            c_OP_NOT: w_res = ~Ain;
            c_OP_SHL: w_res = Ain;
            default:  w_res = '0;
        endcase
        w_shamt = Bin[c_SHW-1:0];
        w_fast  = !(((op_sel == c_OP_SHL) && (w_shamt != '0)) ||
                    ((op_sel == c_OP_MUL) && (MUL_EN != 0)));
    end

    // One shift or one multiplier bit per BUSY cycle
    always_comb begin
        w_prod_next = r_prod + (r_b[0] ? r_mcand : '0);
        w_busy_res  = r_is_mul ? w_prod_next[WIDTH-1:0] : {r_a[WIDTH-2:0], 1'b0};
        w_busy_c    = r_is_mul ? (|w_prod_next[2*WIDTH-1:WIDTH]) : r_a[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            alu_out  <= '0;
            Carryout <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (w_fast) begin
                            alu_out  <= w_res;
                            Carryout <= w_cf;
                            flag_z   <= (w_res == '0);
                            flag_n   <= w_res[WIDTH-1];
                            flag_v   <= w_vf;
                            r_state  <= c_DONE;
                        end else begin
                            r_a      <= Ain;
                            r_b      <= Bin;
                            r_mcand  <= {{WIDTH{1'b0}}, Ain};
                            r_prod   <= '0;
                            r_is_mul <= (op_sel == c_OP_MUL);
                            r_cnt    <= (op_sel == c_OP_MUL) ? c_MUL_CNT : {1'b0, w_shamt};
                            r_state  <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    r_a     <= {r_a[WIDTH-2:0], 1'b0};
                    r_b     <= r_b >> 1;
                    r_mcand <= r_mcand << 1;
                    r_prod  <= w_prod_next;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == c_CW'(1)) begin
                        alu_out  <= w_busy_res;
                        Carryout <= w_busy_c;
                        flag_z   <= (w_busy_res == '0);
                        flag_n   <= w_busy_res[WIDTH-1];
                        flag_v   <= 1'b0;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_pw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_pw
//  Description : Self-checking bench for alu_seq_pw against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_pw;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] Ain = 8'h00;
    logic [7:0] Bin = 8'h00;
    logic       Carryin = 1'b0;
    logic       carry_sel = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] alu_out;
    logic       Carryout;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;

    int total = 0;
    int bad   = 0;
    int m_c   = 0;

    alu_seq_pw #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Ain(Ain), .Bin(Bin), .Carryin(Carryin), .carry_sel(carry_sel),
        .op_sel(op_sel), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .Carryout(Carryout), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    function automatic int to_s(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void ref_model(input int a, input int b, input int c, input int op,
                                      output int res, output int cf, output int vf,
                                      output int lat);
        int s;
        int k;
        res = 0; cf = 0; vf = 0; lat = 1;
        case (op)
            0: begin
                s = a + b + c; res = s % 256; cf = (s >= 256) ? 1 : 0;
                s = to_s(a) + to_s(b) + c; vf = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                s = a + (255 - b) + c; res = s % 256; cf = (s >= 256) ? 1 : 0;
                s = to_s(a) - to_s(b) - 1 + c; vf = (s > 127 || s < -128) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin
                k = b % 8; res = (a << k) % 256;
                cf = (k == 0) ? 0 : ((a >> (8 - k)) & 1); lat = k + 1;
            end
            default: begin
                s = a * b; res = s % 256; cf = (s > 255) ? 1 : 0; lat = 9;
            end
        endcase
    endfunction

    // Drives one operation and returns what the DUT presented; lat=-1 on timeout
    task automatic issue(input int a, input int b, input int cin, input int csel, input int op,
                         input bit hold, output int res, output int cf, output int z,
                         output int n, output int v, output int lat);
        @(negedge clk);
        Ain = 8'(a); Bin = 8'(b); Carryin = cin[0]; carry_sel = csel[0];
        op_sel = 3'(op); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = int'(alu_out); cf = int'(Carryout); z = int'(flag_z);
        n = int'(flag_n); v = int'(flag_v);
        if (!hold) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if ({alu_out, Carryout, flag_z, flag_n, flag_v} !== 12'h000) begin
            bad++; $display("FAIL reset_data: out=%h c=%b z=%b n=%b v=%b want all 0",
                            alu_out, Carryout, flag_z, flag_n, flag_v);
        end
        @(negedge clk); reset = 1'b0;
        m_c = 0;
    endtask

    int va[7]   = '{8'hCC, 8'h08, 8'hFF, 8'hE1, 8'hE1, 8'h10, 8'h20};
    int vb[7]   = '{8'h55, 8'h06, 8'h00, 3,     0,     8'h06, 8'h10};
    int vcin[7] = '{1, 1, 0, 0, 0, 0, 0};
    int vcs[7]  = '{0, 0, 1, 0, 0, 0, 0};
    int vop[7]  = '{0, 1, 0, 6, 6, 7, 7};
    int vres[7] = '{8'h22, 8'h02, 8'h00, 8'h08, 8'hE1, 8'h60, 8'h00};
    int vcf[7]  = '{1, 1, 1, 1, 0, 0, 1};
    int vz[7]   = '{0, 0, 1, 0, 0, 0, 1};
    int vlat[7] = '{1, 1, 1, 4, 1, 9, 9};

    task automatic test_directed;
        int res, cf, z, n, v, lat;
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vcin[i], vcs[i], vop[i], 1'b0, res, cf, z, n, v, lat);
            total++;
            if (res != vres[i] || cf != vcf[i] || z != vz[i]) begin
                bad++; $display("FAIL dir%0d_data: res=%h c=%0d z=%0d want %h/%0d/%0d",
                                i, res, cf, z, vres[i], vcf[i], vz[i]);
            end
            total++;
            if (lat != vlat[i]) begin
                bad++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, vlat[i]);
            end
            total++;
            if (n != (vres[i] >> 7) || (i == 0 && v != 0)) begin
                bad++; $display("FAIL dir%0d_nv: n=%0d v=%0d want n=%0d", i, n, v, vres[i] >> 7);
            end
            m_c = vcf[i];
        end
    endtask

    task automatic test_random;
        int a, b, cin, cs, op, eres, ecf, evf, elat, res, cf, z, n, v, lat;
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
            cin = int'($urandom_range(0, 1)); cs = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 7));
            ref_model(a, b, (cs != 0) ? m_c : cin, op, eres, ecf, evf, elat);
            issue(a, b, cin, cs, op, 1'b0, res, cf, z, n, v, lat);
            total++;
            if (res != eres || cf != ecf || v != evf || lat != elat ||
                z != ((eres == 0) ? 1 : 0) || n != (eres >> 7)) begin
                bad++;
                $display("FAIL rnd%0d op%0d a=%h b=%h: res=%h c=%0d v=%0d z=%0d n=%0d lat=%0d want %h/%0d/%0d lat=%0d",
                         i, op, a, b, res, cf, v, z, n, lat, eres, ecf, evf, elat);
            end
            m_c = ecf;
        end
    endtask

    task automatic test_stall;
        int res, cf, z, n, v, lat;
        issue(8'h7F, 8'h01, 0, 0, 0, 1'b1, res, cf, z, n, v, lat);
        total++;
        if (res != 8'h80 || cf != 0 || v != 1 || n != 1 || z != 0) begin
            bad++; $display("FAIL stall_first: res=%h c=%0d v=%0d n=%0d want 80/0/1/1", res, cf, v, n);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Ain = 8'($urandom); Bin = 8'($urandom); op_sel = 3'd4; in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if (alu_out !== 8'h80 || Carryout !== 1'b0 || flag_v !== 1'b1 || flag_n !== 1'b1 ||
                in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d: out=%h c=%b v=%b n=%b in_ready=%b out_valid=%b",
                                i, alu_out, Carryout, flag_v, flag_n, in_ready, out_valid);
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        m_c = 0;
        issue(8'h0F, 8'hF0, 0, 0, 3, 1'b0, res, cf, z, n, v, lat);
        total++;
        if (res != 8'hFF || lat != 1) begin
            bad++; $display("FAIL stall_next: res=%h lat=%0d want ff/1", res, lat);
        end
    endtask

    task automatic test_reset_mid_op;
        int res, cf, z, n, v, lat;
        issue(8'hCC, 8'h55, 1, 0, 0, 1'b0, res, cf, z, n, v, lat);
        @(negedge clk);
        Ain = 8'hFF; Bin = 8'hFF; op_sel = 3'd7; carry_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 8'h00 ||
            {Carryout, flag_z, flag_n, flag_v} !== 4'h0) begin
            bad++; $display("FAIL mid_reset: out_valid=%b in_ready=%b out=%h c=%b z=%b n=%b v=%b",
                            out_valid, in_ready, alu_out, Carryout, flag_z, flag_n, flag_v);
        end
        @(negedge clk); reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_stale: out_valid=%b want 0", out_valid);
        end
        issue(8'h01, 8'h01, 1, 1, 0, 1'b0, res, cf, z, n, v, lat);
        total++;
        if (res != 8'h02 || cf != 0) begin
            bad++; $display("FAIL chain_after_reset: res=%h c=%0d want 02/0", res, cf);
        end
        m_c = 0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_stall;
        test_reset_mid_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
